// File: rtl/mem_writer_if.sv
// mem_writer_if: request/operand and memory-bus signals of the stack/store writer.
// master = execute-stage side issuing requests, slave = mem_writer itself.
interface mem_writer_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  write_req;
    logic [1:0]            write_mode;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [REG_WIDTH-1:0]  data_in;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [REG_WIDTH-1:0]  p_in;
    logic [REG_WIDTH-1:0]  sp_in;

    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  data_out;
    logic                  write_en;
    logic [REG_WIDTH-1:0]  sp_next;
    logic                  busy;
    logic                  write_done;
    logic                  sp_wrap;

    modport master (
        output write_req, write_mode, addr_in, data_in, pc_in, p_in, sp_in,
        input  addr, data_out, write_en, sp_next, busy, write_done, sp_wrap
    );

    modport slave (
        input  write_req, write_mode, addr_in, data_in, pc_in, p_in, sp_in,
        output addr, data_out, write_en, sp_next, busy, write_done, sp_wrap
    );
endinterface

// File: rtl/mem_writer.sv
// mem_writer: single-byte stores and 1-3 byte stack pushes onto the memory bus,
// one byte per phi1 cycle, all outputs registered.
// Optional feature macro: MEM_WRITER_STACK_WRAP_EN (sticky sp_wrap flag).
//
// state | meaning
// IDLE  | waiting for write_req, busy low
// WR0   | first (or only) byte on the bus
// WR1   | second push byte (pc low)
// WR2   | third push byte (status)
// DONE  | write_done pulse, then back to IDLE
module mem_writer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic phi1,
    input  logic reset,
    mem_writer_if.slave bus
);

    localparam logic [1:0] MODE_STORE = 2'b00;
    localparam logic [1:0] MODE_PUSH1 = 2'b01;
    localparam logic [1:0] MODE_PUSH3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [REG_WIDTH-1:0]  pc_lo_q;
    logic [REG_WIDTH-1:0]  p_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  data_q, data_d;
    logic                  write_en_q, write_en_d;
    logic [REG_WIDTH-1:0]  sp_q, sp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  is_push;
    logic [REG_WIDTH-1:0]  sp_dec;
`ifdef MEM_WRITER_STACK_WRAP_EN
    logic                  wrap_q, wrap_d;
`endif

    // Stack page address; sp is 8-bit so the address never leaves the page.
    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] sp);
        return STACK_BASE + {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, sp};
    endfunction

    assign accept  = (state_q == IDLE) && bus.write_req;
    assign is_push = (mode_q != MODE_STORE);
    assign sp_dec  = sp_q - REG_WIDTH'(1);

    // State register.
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: byte count follows the latched mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.write_req) state_d = WR0;
            WR0:  state_d = (mode_q == MODE_STORE || mode_q == MODE_PUSH1) ? DONE : WR1;
            WR1:  state_d = (mode_q == MODE_PUSH3) ? WR2 : DONE;
            WR2:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computes next cycle's registered bus values so each byte
    // appears on the bus in the cycle its state is active.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        write_en_d = 1'b0;
        sp_d       = sp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef MEM_WRITER_STACK_WRAP_EN
        wrap_d     = wrap_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.write_req) begin
                    busy_d     = 1'b1;
                    write_en_d = 1'b1;
                    if (bus.write_mode == MODE_STORE) begin
                        addr_d = bus.addr_in;
                        data_d = bus.data_in;
                    end else begin
                        sp_d   = bus.sp_in;
                        addr_d = stack_addr(bus.sp_in);
                        data_d = (bus.write_mode == MODE_PUSH1) ? bus.data_in
                                                                : bus.pc_in[ADDR_WIDTH-1 -: REG_WIDTH];
                    end
                end
            end
            WR0, WR1, WR2: begin
                if (is_push) begin
                    sp_d = sp_dec;
`ifdef MEM_WRITER_STACK_WRAP_EN
                    if (sp_q == '0) wrap_d = 1'b1;
`endif
                end
                if (state_d == DONE) begin
                    done_d = 1'b1;
                end else begin
                    write_en_d = 1'b1;
                    addr_d     = stack_addr(sp_dec);
                    data_d     = (state_d == WR1) ? pc_lo_q : p_q;
                end
            end
            DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    // Operand capture on acceptance; later bytes come from these copies.
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_STORE;
            pc_lo_q <= '0;
            p_q     <= '0;
        end else if (accept) begin
            mode_q  <= bus.write_mode;
            pc_lo_q <= bus.pc_in[REG_WIDTH-1:0];
            p_q     <= bus.p_in;
        end
    end

    // Registered outputs.
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            data_q     <= '0;
            write_en_q <= 1'b0;
            sp_q       <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
            sp_q       <= sp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef MEM_WRITER_STACK_WRAP_EN
    // Sticky wrap flag, cleared only by reset.
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
    assign bus.sp_wrap = wrap_q;
`else
    assign bus.sp_wrap = 1'b0;
`endif

    assign bus.addr       = addr_q;
    assign bus.data_out   = data_q;
    assign bus.write_en   = write_en_q;
    assign bus.sp_next    = sp_q;
    assign bus.busy       = busy_q;
    assign bus.write_done = done_q;

endmodule

// File: tb/tb_mem_writer.sv
module tb_mem_writer;

    logic phi1  = 1'b0;
    logic reset = 1'b1;
    always #5 phi1 = ~phi1;

    mem_writer_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    mem_writer #(
        .REG_WIDTH (8),
        .ADDR_WIDTH(16),
        .STACK_BASE(16'h0100)
    ) dut (
        .phi1 (phi1),
        .reset(reset),
        .bus  (bus)
    );

`ifdef MEM_WRITER_STACK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]       mode;
        logic [15:0]      a;
        logic [7:0]       d;
        logic [15:0]      pc;
        logic [7:0]       p;
        logic [7:0]       sp;
        int               k;
        logic [2:0][15:0] ea;
        logic [2:0][7:0]  ed;
        logic [7:0]       esp;
        logic             ewrap;
    } vec_t;

    vec_t tbl [7];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  model_sp    = 8'hFF;
    logic        model_wrap  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " addr"},       32'(bus.addr),       32'h0);
        chk({tag, " data_out"},   32'(bus.data_out),   32'h0);
        chk({tag, " write_en"},   32'(bus.write_en),   32'h0);
        chk({tag, " sp_next"},    32'(bus.sp_next),    32'hFF);
        chk({tag, " busy"},       32'(bus.busy),       32'h0);
        chk({tag, " write_done"}, 32'(bus.write_done), 32'h0);
        chk({tag, " sp_wrap"},    32'(bus.sp_wrap),    32'h0);
    endtask

    task automatic drive_req(input logic [1:0] mode, input logic [15:0] a, input logic [7:0] d,
                             input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp);
        bus.write_mode = mode;
        bus.addr_in    = a;
        bus.data_in    = d;
        bus.pc_in      = pc;
        bus.p_in       = p;
        bus.sp_in      = sp;
        bus.write_req  = 1'b1;
    endtask

    // Operands must be latched at acceptance, so garbage afterwards is harmless.
    task automatic scramble();
        bus.write_mode = 2'($urandom);
        bus.addr_in    = 16'($urandom);
        bus.data_in    = 8'($urandom);
        bus.pc_in      = 16'($urandom);
        bus.p_in       = 8'($urandom);
        bus.sp_in      = 8'($urandom);
    endtask

    // Reference: list of (address, byte) writes the request should produce.
    task automatic model_txn(input logic [1:0] mode, input logic [15:0] a, input logic [7:0] d,
                             input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                             output int k, output logic [2:0][15:0] ea, output logic [2:0][7:0] ed,
                             output logic [7:0] esp, output logic ewrap);
        logic [7:0] vals [3];
        logic [7:0] s;
        logic       w;
        ea = '0;
        ed = '0;
        w  = 1'b0;
        if (mode == 2'b00) begin
            k     = 1;
            ea[0] = a;
            ed[0] = d;
            esp   = model_sp;
        end else begin
            k = int'(mode);
            if (k == 1) begin
                vals[0] = d;
            end else begin
                vals[0] = pc[15:8];
                vals[1] = pc[7:0];
                vals[2] = p;
            end
            for (int i = 0; i < k; i++) begin
                s     = sp - 8'(i);
                ea[i] = 16'h0100 + {8'h00, s};
                ed[i] = vals[i];
                if (s == 8'h00) w = 1'b1;
            end
            esp = sp - 8'(k);
        end
        ewrap = model_wrap | (WRAP_EN & w);
    endtask

    // Issue one request from an idle negedge and check every cycle through the following IDLE.
    task automatic apply_txn(input string tag, input logic [1:0] mode, input logic [15:0] a,
                             input logic [7:0] d, input logic [15:0] pc, input logic [7:0] p,
                             input logic [7:0] sp, input int k, input logic [2:0][15:0] ea,
                             input logic [2:0][7:0] ed, input logic [7:0] esp, input logic ewrap);
        logic [7:0] sp_byte;
        drive_req(mode, a, d, pc, p, sp);
        @(negedge phi1);
        bus.write_req = 1'b0;
        scramble();
        for (int j = 0; j < k; j++) begin
            sp_byte = (mode == 2'b00) ? model_sp : sp - 8'(j);
            chk({tag, " write_en"},   32'(bus.write_en),   32'h1);
            chk({tag, " addr"},       32'(bus.addr),       32'(ea[j]));
            chk({tag, " data_out"},   32'(bus.data_out),   32'(ed[j]));
            chk({tag, " busy"},       32'(bus.busy),       32'h1);
            chk({tag, " write_done"}, 32'(bus.write_done), 32'h0);
            chk({tag, " sp_next"},    32'(bus.sp_next),    32'(sp_byte));
            @(negedge phi1);
        end
        chk({tag, " done pulse"},  32'(bus.write_done), 32'h1);
        chk({tag, " done we"},     32'(bus.write_en),   32'h0);
        chk({tag, " done busy"},   32'(bus.busy),       32'h1);
        chk({tag, " done sp"},     32'(bus.sp_next),    32'(esp));
        chk({tag, " done wrap"},   32'(bus.sp_wrap),    32'(ewrap));
        @(negedge phi1);
        chk({tag, " idle busy"},   32'(bus.busy),       32'h0);
        chk({tag, " idle done"},   32'(bus.write_done), 32'h0);
        chk({tag, " idle we"},     32'(bus.write_en),   32'h0);
        chk({tag, " idle sp"},     32'(bus.sp_next),    32'(esp));
        model_sp   = esp;
        model_wrap = ewrap;
    endtask

    task automatic count_cycles(input int n, inout int we, inout int dn);
        for (int i = 0; i < n; i++) begin
            @(negedge phi1);
            we += int'(bus.write_en);
            dn += int'(bus.write_done);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               k, we, dn;
        logic [2:0][15:0] ea;
        logic [2:0][7:0]  ed;
        logic [7:0]       esp, sp;
        logic             ew;
        logic [1:0]       mode;
        logic [15:0]      a, pc;
        logic [7:0]       d, p;
        logic [4:0]       we_pat, dn_pat;

        tbl[0] = '{2'b00, 16'h0200, 8'h42, 16'h0000, 8'h00, 8'h55, 1,
                   {16'h0, 16'h0, 16'h0200}, {8'h0, 8'h0, 8'h42}, 8'hFF, 1'b0};
        tbl[1] = '{2'b01, 16'h0000, 8'hA5, 16'h0000, 8'h00, 8'hFF, 1,
                   {16'h0, 16'h0, 16'h01FF}, {8'h0, 8'h0, 8'hA5}, 8'hFE, 1'b0};
        tbl[2] = '{2'b11, 16'h0000, 8'h00, 16'h1234, 8'h30, 8'hFD, 3,
                   {16'h01FB, 16'h01FC, 16'h01FD}, {8'h30, 8'h34, 8'h12}, 8'hFA, 1'b0};
        tbl[3] = '{2'b00, 16'h3456, 8'h99, 16'h0000, 8'h00, 8'h10, 1,
                   {16'h0, 16'h0, 16'h3456}, {8'h0, 8'h0, 8'h99}, 8'hFA, 1'b0};
        tbl[4] = '{2'b10, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 8'h00, 2,
                   {16'h0, 16'h01FF, 16'h0100}, {8'h0, 8'hEF, 8'hBE}, 8'hFE, 1'b1};
        tbl[5] = '{2'b11, 16'h0000, 8'h00, 16'hA0B1, 8'hC2, 8'h01, 3,
                   {16'h01FF, 16'h0100, 16'h0101}, {8'hC2, 8'hB1, 8'hA0}, 8'hFE, 1'b1};
        tbl[6] = '{2'b01, 16'h0000, 8'h5A, 16'h0000, 8'h00, 8'h80, 1,
                   {16'h0, 16'h0, 16'h0180}, {8'h0, 8'h0, 8'h5A}, 8'h7F, 1'b1};

        bus.write_req = 1'b0;
        drive_req(2'b00, 16'h0, 8'h0, 16'h0, 8'h0, 8'h0);
        bus.write_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge phi1);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge phi1);
        check_reset_vals("post-reset idle");

        // Directed vectors from the table.
        for (int i = 0; i < 7; i++) begin
            apply_txn($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].a, tbl[i].d, tbl[i].pc,
                      tbl[i].p, tbl[i].sp, tbl[i].k, tbl[i].ea, tbl[i].ed, tbl[i].esp,
                      tbl[i].ewrap & WRAP_EN);
        end

        // Request held high through DONE: PUSH1 accepted twice, 3 cycles apart.
        drive_req(2'b01, 16'h0, 8'h11, 16'h0, 8'h0, 8'h40);
        we_pat = '0;
        dn_pat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge phi1);
            we_pat[i] = bus.write_en;
            dn_pat[i] = bus.write_done;
            if (i == 3) bus.write_req = 1'b0;
        end
        chk("held req we pattern",   32'(we_pat), 32'b01001);
        chk("held req done pattern", 32'(dn_pat), 32'b10010);
        chk("held req sp",           32'(bus.sp_next), 32'h3F);
        @(negedge phi1);
        model_sp = 8'h3F;

        // Second request pulsed during WR1 of a PUSH2 is dropped.
        drive_req(2'b10, 16'h0, 8'h0, 16'h5566, 8'h0, 8'h90);
        we = 0;
        dn = 0;
        count_cycles(1, we, dn);
        bus.write_req = 1'b0;
        count_cycles(1, we, dn);
        drive_req(2'b00, 16'h0777, 8'h77, 16'h0, 8'h0, 8'h0);
        count_cycles(1, we, dn);
        bus.write_req = 1'b0;
        count_cycles(4, we, dn);
        chk("ignored req write_en pulses", 32'(we), 32'd2);
        chk("ignored req done pulses",     32'(dn), 32'd1);
        chk("ignored req sp",              32'(bus.sp_next), 32'h8E);
        model_sp = 8'h8E;

        // Randomized requests against the reference model.
        for (int i = 0; i < 150; i++) begin
            mode = 2'($urandom);
            a    = 16'($urandom);
            d    = 8'($urandom);
            pc   = 16'($urandom);
            p    = 8'($urandom);
            sp   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            model_txn(mode, a, d, pc, p, sp, k, ea, ed, esp, ew);
            apply_txn($sformatf("rand%0d", i), mode, a, d, pc, p, sp, k, ea, ed, esp, ew);
            repeat ($urandom_range(0, 2)) @(negedge phi1);
        end

        // Reset asserted together with a request: nothing is written.
        drive_req(2'b01, 16'h0, 8'hCC, 16'h0, 8'h0, 8'h20);
        reset = 1'b1;
        we = 0;
        dn = 0;
        count_cycles(2, we, dn);
        bus.write_req = 1'b0;
        reset = 1'b0;
        count_cycles(3, we, dn);
        chk("reset+req write_en pulses", 32'(we), 32'd0);
        chk("reset+req busy",            32'(bus.busy), 32'h0);
        chk("reset+req sp",              32'(bus.sp_next), 32'hFF);

        // Reset after the first byte of a PUSH3: transaction abandoned.
        drive_req(2'b11, 16'h0, 8'h0, 16'hCAFE, 8'h21, 8'h50);
        we = 0;
        dn = 0;
        count_cycles(1, we, dn);
        bus.write_req = 1'b0;
        chk("mid-reset first byte addr", 32'(bus.addr), 32'h0150);
        reset = 1'b1;
        #1;
        check_reset_vals("mid-reset");
        count_cycles(2, we, dn);
        reset = 1'b0;
        count_cycles(5, we, dn);
        chk("mid-reset write_en pulses", 32'(we), 32'd1);
        chk("mid-reset done pulses",     32'(dn), 32'd0);
        check_reset_vals("after mid-reset");
        model_sp   = 8'hFF;
        model_wrap = 1'b0;

        // Recovery after reset.
        apply_txn("recover", tbl[1].mode, tbl[1].a, tbl[1].d, tbl[1].pc, tbl[1].p, tbl[1].sp,
                  tbl[1].k, tbl[1].ea, tbl[1].ed, tbl[1].esp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_writer.md
# mem_writer

Write-side counterpart of the instruction fetcher. Performs single-byte stores and 1–3 byte stack pushes (PHA/PHP, JSR, BRK/IRQ) onto the shared memory bus, driving `addr`, `data_out` and `write_en` one byte per `phi1` cycle. For pushes it returns the updated stack pointer. The block sits between the execute stage and the memory bus arbiter.

## Interface
Parameters:
- REG_WIDTH, `REG_WIDTH` (8), data and register width
- ADDR_WIDTH, `ADDR_WIDTH` (16), bus address width
- STACK_BASE, `STACK_BASE` (16'h0100), stack page base address

Ports:
- phi1  input  1  sole clock; all state changes on posedge
- reset  input  1  asynchronous, active-high reset
- write_req  input  1  request strobe; sampled only in IDLE
- write_mode  input  2  00 STORE, 01 PUSH1, 10 PUSH2, 11 PUSH3
- addr_in  input  ADDR_WIDTH  target address for STORE
- data_in  input  REG_WIDTH  byte for STORE and PUSH1
- pc_in  input  ADDR_WIDTH  return address for PUSH2 and PUSH3
- p_in  input  REG_WIDTH  status byte, third byte of PUSH3
- sp_in  input  REG_WIDTH  current stack pointer
- addr  output  ADDR_WIDTH  bus write address
- data_out  output  REG_WIDTH  bus write data
- write_en  output  1  high for exactly one cycle per byte written
- sp_next  output  REG_WIDTH  updated stack pointer
- busy  output  1  high from acceptance until DONE
- write_done  output  1  one-cycle completion pulse
- sp_wrap  output  1  sticky stack-wrap flag (see Configuration)

## Operation
- All outputs are registered.
- States: IDLE, WR0, WR1, WR2, DONE.
- IDLE: `busy`=0. If `write_req`=1 at a posedge, latch all operands and set `busy`=1:
  - STORE goes to WR0.
  - Any PUSH goes to WR0 with `sp_next`=`sp_in`.
- STORE, WR0: `addr`=`addr_in`, `data_out`=`data_in`, `write_en`=1. Next state DONE.
- PUSH sequence, in order:
  - PUSH1 writes `data_in`.
  - PUSH2 writes `pc_in[15:8]`, then `pc_in[7:0]`.
  - PUSH3 writes `pc_in[15:8]`, then `pc_in[7:0]`, then `p_in`.
  - Use one state per byte: WR0, WR1, WR2.
- Each push byte:
  - `addr` = STACK_BASE + current sp (8-bit sp zero-extended).
  - `write_en`=1.
  - sp decrements after the write and is visible on `sp_next` the following cycle.
- sp arithmetic is 8-bit modulo. 0x00 decrements to 0xFF, and the address stays inside the 0x01xx page.
- After the last byte, go to DONE. DONE lasts one cycle: `write_done`=1, `write_en`=0, `busy`=0 on exit, then return to IDLE.
- `write_req` while `busy`=1 is ignored; nothing is queued.
- A request held high through DONE is accepted again on the IDLE cycle that follows.
- `sp_next` holds its last value in IDLE and DONE. STORE never changes `sp_next`.

## Timing
- Reset values: `addr`=0, `data_out`=0, `write_en`=0, `sp_next`=8'hFF, `busy`=0, `write_done`=0, `sp_wrap`=0, state IDLE.
- Latency, with the request accepted at edge N:
  - First `write_en` is high in cycle N+1.
  - A transaction of k bytes has `write_en` high in cycles N+1..N+k.
  - `write_done` is high in cycle N+k+1.
- Minimum request-to-request spacing is k+2 cycles.
- `write_en` is never high in IDLE or DONE and never high for two writes to the same address within one transaction.
- Reset mid-transaction:
  - All outputs clear immediately.
  - No further bytes are written and no `write_done` is issued.
  - The transaction is abandoned, not resumed.
- Reset asserted together with `write_req`: reset wins.

## Configuration
- Macro: `MEM_WRITER_STACK_WRAP_EN`.
- Defined:
  - `sp_wrap` sets when any push byte is written with sp=0x00, i.e. the decrement wraps to 0xFF.
  - It stays set until reset.
- Undefined:
  - `sp_wrap` is tied to 0.
  - Wrap still occurs silently with the same address and sp behaviour.

## Test plan
- STORE, `addr_in`=0x0200, `data_in`=0x42 -> one `write_en` cycle with addr 0x0200, data 0x42. `write_done` the next cycle. `sp_next` unchanged (0xFF after reset).
- PUSH1, `sp_in`=0xFF, `data_in`=0xA5 -> write 0x01FF=0xA5. `sp_next`=0xFE. `write_done` at N+2.
- PUSH3, `pc_in`=0x1234, `p_in`=0x30, `sp_in`=0xFD -> writes 0x01FD=0x12, 0x01FC=0x34, 0x01FB=0x30 in consecutive cycles. `sp_next`=0xFA.
- PUSH2, `sp_in`=0x00, `pc_in`=0xBEEF -> writes 0x0100=0xBE, then 0x01FF=0xEF. `sp_next`=0xFE. `sp_wrap`=1 if the macro is defined, else 0.
- PUSH3 with `reset` asserted after the first byte -> exactly one `write_en` pulse, outputs at reset values, no `write_done`.
- Second `write_req` pulsed during the WR1 state of a PUSH2 -> ignored. Exactly 2 `write_en` pulses and 1 `write_done`.
